// File: rtl/tvg_curve_gen_if.sv
// Point bus from the TVG curve sequencer to the four-channel DAC serializer.
// The sequencer drives the point and o_vld; the DAC stage answers with i_rdy.
interface tvg_dac_if;
   localparam int unsigned CH_W = 10;

   logic [CH_W-1:0] o_data_0a;
   logic [CH_W-1:0] o_data_0b;
   logic [CH_W-1:0] o_data_1a;
   logic [CH_W-1:0] o_data_1b;
   logic            o_vld;
   logic            i_rdy;

   modport master (
      output o_data_0a,
      output o_data_0b,
      output o_data_1a,
      output o_data_1b,
      output o_vld,
      input  i_rdy
   );

   modport slave (
      input  o_data_0a,
      input  o_data_0b,
      input  o_data_1a,
      input  o_data_1b,
      input  o_vld,
      output i_rdy
   );
endinterface

// File: rtl/tvg_curve_gen.sv
// Time-varied-gain curve sequencer: plays a table of four-channel gain points
// to the DAC stage on each shot sync, one point per programmed period.
// Optional feature macro TVG_PARK_EN: after the last point, present one
// all-zero park point before returning to idle.
module tvg_curve_gen #(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_wr_en,
   input  logic [ADDR_W-1:0]   i_wr_addr,
   input  logic [39:0]         i_wr_data,
   input  logic                i_sync,
   input  logic [ADDR_W-1:0]   i_len,
   input  logic [PERIOD_W-1:0] i_period,
   tvg_dac_if.master           dac,
   output logic                o_busy,
   output logic                o_done
);

   localparam int unsigned CH_W   = 10;
   localparam int unsigned WORD_W = 4 * CH_W;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_SEND = 3'd2,
`ifdef TVG_PARK_EN
      ST_WAIT = 3'd3,
      ST_PARK = 3'd4
`else
      ST_WAIT = 3'd3
`endif
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic [WORD_W-1:0]   data_q, data_d;
   logic                vld_q, vld_d;
   logic                busy_q, busy_d;
   logic                done_c;
   logic                xfer_c;
   logic [WORD_W-1:0]   mem_q [DEPTH];

   assign xfer_c = vld_q & dac.i_rdy;

   // Curve table write port; contents survive reset and are never cleared.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         mem_q[i_wr_addr] <= i_wr_data;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         period_q <= '0;
         cnt_q    <= '0;
         data_q   <= '0;
         vld_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         len_q    <= len_d;
         period_q <= period_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
         busy_q   <= busy_d;
      end
   end

   // Next-state, table read (the data register is the RAM read register),
   // and the final-transfer strobe.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      len_d    = len_q;
      period_d = period_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      done_c   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_sync) begin
               len_d    = i_len;
               period_d = i_period;
               addr_d   = '0;
               state_d  = ST_READ;
            end
         end

         ST_READ: begin
            // Registered read of the old word even if the same address is written now.
            data_d  = mem_q[addr_q];
            state_d = ST_SEND;
         end

         ST_SEND: begin
            if (xfer_c) begin
               if (addr_q == len_q) begin
`ifdef TVG_PARK_EN
                  state_d = ST_PARK;
                  if (!i_sync) begin
                     data_d = '0;
                  end
`else
                  state_d = ST_IDLE;
                  done_c  = ~i_sync;
`endif
               end else begin
                  addr_d  = addr_q + ADDR_W'(1);
                  cnt_d   = period_q;
                  state_d = (period_q != '0) ? ST_WAIT : ST_READ;
               end
            end
         end

         ST_WAIT: begin
            if (cnt_q <= PERIOD_W'(1)) begin
               state_d = ST_READ;
            end else begin
               cnt_d = cnt_q - PERIOD_W'(1);
            end
         end

`ifdef TVG_PARK_EN
         ST_PARK: begin
            if (xfer_c) begin
               state_d = ST_IDLE;
               done_c  = ~i_sync;
            end
         end
`endif

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A sync outside idle restarts the curve; any transfer this cycle still completes.
      if ((state_q != ST_IDLE) && i_sync) begin
         len_d    = i_len;
         period_d = i_period;
         addr_d   = '0;
         state_d  = ST_READ;
      end
   end

   // Valid and busy are registered decodes of the next state.
   always_comb begin
      vld_d  = (state_d == ST_SEND);
`ifdef TVG_PARK_EN
      vld_d  = vld_d | (state_d == ST_PARK);
`endif
      busy_d = (state_d != ST_IDLE);
   end

   assign dac.o_data_0a = data_q[0*CH_W +: CH_W];
   assign dac.o_data_0b = data_q[1*CH_W +: CH_W];
   assign dac.o_data_1a = data_q[2*CH_W +: CH_W];
   assign dac.o_data_1b = data_q[3*CH_W +: CH_W];
   assign dac.o_vld     = vld_q;
   assign o_busy        = busy_q;
   assign o_done        = done_c;

endmodule
